// File: rtl/apb_pkg.sv
// Shared APB definitions used by the master sequencer and the AXI4-lite
// front-end: the state encoding of the sequencer and the response codes the
// front-end derives from err_flag.
package apb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/apb_addr_decoder.sv
// Slave decode for the shared APB bus.
// Ports:
//   sel_field  in   SEL_W       slave-index field taken from the address
//   sel        out  NUM_SLAVES  one-hot select, all zero on a decode error
//   dec_err    out  1           index names a slave that does not exist
module apb_addr_decoder #(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = 2
) (
  input  logic [SEL_W-1:0]      sel_field,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  dec_err
);

  // The field can encode more indices than there are slaves.
  assign dec_err = (int'(sel_field) >= NUM_SLAVES);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      sel[i] = !dec_err && (int'(sel_field) == i);
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master sequencer behind the AXI4-lite front-end. Takes one-cycle
// transfer requests, decodes the target slave and runs SETUP/ACCESS with
// wait states and slave errors, then returns read data, an error flag and a
// one-cycle done pulse.
// Build option: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES
// cycles without PREADY from the selected slave.
// Ports:
//   ACLK, ARESETn           clock, synchronous active-low reset
//   transfer/read/write     request strobe and direction (write wins)
//   apb_waddr/apb_raddr     request addresses
//   apb_wdata, wstrb        write data and byte strobes
//   apb_rdata, err_flag     result, held until the next accepted transfer
//   apb_done                one-cycle completion pulse
//   PADDR..PSTRB            APB master outputs
//   PRDATA/PREADY/PSLVERR   per-slave APB returns (PRDATA flattened)
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 12,
  parameter int SEL_W          = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             ACLK,
  input  logic                             ARESETn,
  input  logic                             transfer,
  input  logic                             read,
  input  logic                             write,
  input  logic [ADDR_WIDTH-1:0]            apb_waddr,
  input  logic [ADDR_WIDTH-1:0]            apb_raddr,
  input  logic [DATA_WIDTH-1:0]            apb_wdata,
  input  logic [3:0]                       wstrb,
  output logic [DATA_WIDTH-1:0]            apb_rdata,
  output logic                             err_flag,
  output logic                             apb_done,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [3:0]                       PSTRB,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  logic [1:0]            state;
  logic [SEL_W-1:0]      idx_q;
  logic                  req_vld;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [SEL_W-1:0]      req_field;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_err;
  logic                  ready_hit;
  logic                  slverr_hit;
  logic [DATA_WIDTH-1:0] prdata_sel;

  assign req_vld   = transfer & (read | write);
  assign req_addr  = write ? apb_waddr : apb_raddr;
  assign req_field = req_addr[SEL_LSB +: SEL_W];

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W)
  ) u_dec (
    .sel_field (req_field),
    .sel       (dec_sel),
    .dec_err   (dec_err)
  );

  // PSEL is one-hot on the selected slave while SETUP/ACCESS, so masking
  // with it drops returns from every other slave.
  assign ready_hit  = |(PREADY & PSEL);
  assign slverr_hit = |(PSLVERR & PSEL);

  always_comb begin
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (int'(idx_q) == i) prdata_sel = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state     <= IDLE;
      idx_q     <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      apb_rdata <= '0;
      err_flag  <= 1'b0;
      apb_done  <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      apb_done <= 1'b0;
      case (state)
        IDLE: if (req_vld) begin
          PADDR     <= req_addr;
          PWRITE    <= write;
          PWDATA    <= write ? apb_wdata : '0;
          PSTRB     <= write ? wstrb : 4'h0;
          idx_q     <= req_field;
          apb_rdata <= '0;
          if (dec_err) begin
            // No slave owns this address: finish without touching the bus.
            err_flag <= 1'b1;
            apb_done <= 1'b1;
            state    <= DONE;
          end else begin
            err_flag <= 1'b0;
            PSEL     <= dec_sel;
            state    <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        ACCESS: begin
          // PREADY is checked first so a ready in the last allowed cycle
          // beats the timeout.
          if (ready_hit) begin
            if (!PWRITE) apb_rdata <= prdata_sel;
            err_flag <= slverr_hit;
            PSEL     <= '0;
            PENABLE  <= 1'b0;
            apb_done <= 1'b1;
            state    <= DONE;
          end
`ifdef APB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            apb_rdata <= '0;
            err_flag  <= 1'b1;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            apb_done  <= 1'b1;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;  // DONE: pulse already issued on entry
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
module tb_apb_master_ctrl;

  logic         ACLK;
  logic         ARESETn;
  logic         transfer, read, write;
  logic [31:0]  apb_waddr, apb_raddr, apb_wdata;
  logic [3:0]   wstrb;
  logic [31:0]  apb_rdata;
  logic         err_flag, apb_done;
  logic [31:0]  PADDR;
  logic [3:0]   PSEL;
  logic         PENABLE, PWRITE;
  logic [31:0]  PWDATA;
  logic [3:0]   PSTRB;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY, PSLVERR;

  apb_master_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4),
    .SEL_LSB(12), .SEL_W(3), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .transfer(transfer), .read(read), .write(write),
    .apb_waddr(apb_waddr), .apb_raddr(apb_raddr),
    .apb_wdata(apb_wdata), .wstrb(wstrb),
    .apb_rdata(apb_rdata), .err_flag(err_flag), .apb_done(apb_done),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Slave model: selected slave answers after waits[i] ACCESS cycles.
  // With noise set, every other slave and the SETUP phase drive PREADY and
  // PSLVERR high, which the master must ignore.
  int          waits [4];
  bit          errs  [4];
  logic [31:0] prd   [4];
  bit          noise;
  int          acc_cnt;

  always @(posedge ACLK) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

  always_comb begin
    PREADY  = '0;
    PSLVERR = '0;
    PRDATA  = '0;
    for (int i = 0; i < 4; i++) begin
      PRDATA[i*32 +: 32] = prd[i];
      if (PSEL[i] && PENABLE) begin
        if (acc_cnt == waits[i]) begin
          PREADY[i]  = 1'b1;
          PSLVERR[i] = errs[i];
        end
      end else if (noise) begin
        PREADY[i]  = 1'b1;
        PSLVERR[i] = 1'b1;
      end
    end
  end

  int passed = 0;
  int total  = 0;

  typedef struct { logic [31:0] rdata; logic err; int lat; } exp_t;
  exp_t sb [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Issue one request and follow it to apb_done. Cycle 1 is the cycle after
  // the edge that samples transfer. inject fires a second request mid-ACCESS
  // that must be ignored.
  task automatic txn(input string tag, input bit wr, input bit rd,
                     input logic [31:0] wa, input logic [31:0] ra,
                     input logic [31:0] wd, input logic [3:0] st,
                     input logic [3:0] exp_sel, input int lat,
                     input logic [31:0] exp_rd, input bit exp_err, input bit inject);
    exp_t e;
    int cyc;
    logic [31:0] exp_addr;
    exp_addr = wr ? wa : ra;
    sb.push_back('{exp_rd, exp_err, lat});
    write = wr; read = rd; apb_waddr = wa; apb_raddr = ra;
    apb_wdata = wd; wstrb = st; transfer = 1'b1;
    tick();
    transfer = 1'b0; read = 1'b0; write = 1'b0;
    cyc = 1;
    while (apb_done !== 1'b1 && cyc < 200) begin
      if (cyc == 1) begin
        chk({tag, ":setup_psel"}, PSEL, exp_sel);
        chk({tag, ":setup_penable"}, PENABLE, 0);
        chk({tag, ":err_cleared"}, err_flag, 0);
        chk({tag, ":rdata_cleared"}, apb_rdata, 0);
      end
      if (cyc == 2) chk({tag, ":access_penable"}, PENABLE, 1);
      if (PENABLE === 1'b1) begin
        chk({tag, ":psel_stable"}, PSEL, exp_sel);
        chk({tag, ":paddr_stable"}, PADDR, exp_addr);
        chk({tag, ":pwrite"}, PWRITE, wr);
        chk({tag, ":pstrb"}, PSTRB, wr ? st : 4'h0);
        if (wr) chk({tag, ":pwdata"}, PWDATA, wd);
      end
      if (inject && cyc == 2) begin
        transfer = 1'b1; write = 1'b1; apb_waddr = 32'h0000_3000;
      end else begin
        transfer = 1'b0; write = 1'b0;
      end
      tick();
      cyc++;
    end
    transfer = 1'b0; write = 1'b0;
    if (apb_done !== 1'b1) chk({tag, ":done_seen"}, apb_done, 1);
    e = sb.pop_front();
    chk({tag, ":latency"}, cyc, e.lat);
    chk({tag, ":rdata"}, apb_rdata, e.rdata);
    chk({tag, ":err"}, err_flag, e.err);
    chk({tag, ":done_psel"}, PSEL, 0);
    chk({tag, ":done_penable"}, PENABLE, 0);
    tick();
    chk({tag, ":done_pulse"}, apb_done, 0);
    chk({tag, ":rdata_hold"}, apb_rdata, e.rdata);
    chk({tag, ":err_hold"}, err_flag, e.err);
    chk({tag, ":idle_psel"}, PSEL, 0);
  endtask

  initial begin
    ARESETn = 1'b0; transfer = 1'b0; read = 1'b0; write = 1'b0;
    apb_waddr = '0; apb_raddr = '0; apb_wdata = '0; wstrb = '0;
    noise = 1'b0;
    for (int i = 0; i < 4; i++) begin
      waits[i] = 0; errs[i] = 1'b0;
    end
    prd[0] = 32'h0101_0101; prd[1] = 32'h1234_5678;
    prd[2] = 32'hAAAA_5555; prd[3] = 32'h3333_CAFE;

    tick(); tick();
    chk("rst:psel", PSEL, 0);
    chk("rst:penable", PENABLE, 0);
    chk("rst:pwrite", PWRITE, 0);
    chk("rst:paddr", PADDR, 0);
    chk("rst:pwdata", PWDATA, 0);
    chk("rst:pstrb", PSTRB, 0);
    chk("rst:rdata", apb_rdata, 0);
    chk("rst:err", err_flag, 0);
    chk("rst:done", apb_done, 0);
    ARESETn = 1'b1;
    tick();

    // Zero-wait write to slave 2.
    txn("wr_s2", 1, 0, 32'h0000_2004, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF,
        4'b0100, 3, 32'h0, 0, 0);

    // Read slave 1 with three wait states; strobes must not reach PSTRB,
    // and a request arriving mid-ACCESS is dropped.
    waits[1] = 3;
    txn("rd_s1_wait", 0, 1, 32'h0000_0000, 32'h0000_1008, 32'h0, 4'hF,
        4'b0010, 6, 32'h1234_5678, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_s1_wait:rdata_hold_long", apb_rdata, 32'h1234_5678);
      chk("rd_s1_wait:no_queued_txn", PSEL, 0);
    end

    // Slave error on a write to slave 0.
    errs[0] = 1'b1;
    txn("wr_s0_slverr", 1, 0, 32'h0000_0010, 32'h0, 32'h0BAD_F00D, 4'h3,
        4'b0001, 3, 32'h0, 1, 0);
    errs[0] = 1'b0;

    // Back-to-back read of slave 3 with stray PREADY/PSLVERR everywhere else
    // and during SETUP; also clears the previous error.
    waits[3] = 2; noise = 1'b1;
    txn("rd_s3_noise", 0, 1, 32'h0, 32'h0000_3000, 32'h0, 4'h0,
        4'b1000, 5, 32'h3333_CAFE, 0, 0);
    noise = 1'b0; waits[3] = 0;

    // Read and write together: write wins.
    txn("rdwr_both", 1, 1, 32'h0000_3004, 32'h0000_1004, 32'h5A5A_A5A5, 4'h9,
        4'b1000, 3, 32'h0, 0, 0);

    // Decode error: index 5 with four slaves.
    txn("dec_err", 0, 1, 32'h0, 32'h0000_5000, 32'h0, 4'h0,
        4'b0000, 1, 32'h0, 1, 0);

    // transfer without a direction is ignored.
    transfer = 1'b1;
    tick();
    transfer = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("no_dir:psel", PSEL, 0);
      chk("no_dir:done", apb_done, 0);
      tick();
    end

`ifdef APB_TIMEOUT_EN
    waits[2] = 1000;
    txn("timeout", 0, 1, 32'h0, 32'h0000_2000, 32'h0, 4'h0,
        4'b0100, 18, 32'h0, 1, 0);
    waits[2] = 15;
    txn("ready_last", 0, 1, 32'h0, 32'h0000_2000, 32'h0, 4'h0,
        4'b0100, 18, 32'hAAAA_5555, 0, 0);
`endif

    // Stuck slave, then reset during ACCESS.
    waits[2] = 1000;
    read = 1'b1; apb_raddr = 32'h0000_2010; transfer = 1'b1;
    tick();
    read = 1'b0; transfer = 1'b0;
    tick(); tick(); tick();
    chk("stuck:penable", PENABLE, 1);
`ifndef APB_TIMEOUT_EN
    repeat (100) tick();
    chk("stuck_100:penable", PENABLE, 1);
    chk("stuck_100:psel", PSEL, 4'b0100);
    chk("stuck_100:done", apb_done, 0);
`endif
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    chk("mid_rst:psel", PSEL, 0);
    chk("mid_rst:penable", PENABLE, 0);
    chk("mid_rst:paddr", PADDR, 0);
    chk("mid_rst:done", apb_done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst:no_done", apb_done, 0);
    end
    waits[2] = 1;
    txn("after_rst", 0, 1, 32'h0, 32'h0000_2020, 32'h0, 4'h0,
        4'b0100, 4, 32'hAAAA_5555, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- APB master sequencer behind the AXI4-lite front-end.
- Accepts one-cycle transfer requests (transfer/read/write plus latched address, data and strobe). Decodes the target slave from the address and runs APB SETUP/ACCESS phases with wait-state and error handling.
- Returns apb_rdata, err_flag and a one-cycle apb_done pulse to the front-end.
- Shares a single APB bus among NUM_SLAVES slaves.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- NUM_SLAVES, 4, number of APB slaves (1..16).
- SEL_LSB, 12, LSB of the slave-index field in the address.
- SEL_W, 2, width of the slave-index field, = clog2(NUM_SLAVES), minimum 1.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort (used only with APB_TIMEOUT_EN).

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, synchronous, active-low
- transfer  in  1  one-cycle request strobe
- read  in  1  read request, qualifies transfer
- write  in  1  write request, qualifies transfer
- apb_waddr  in  ADDR_WIDTH  write address
- apb_raddr  in  ADDR_WIDTH  read address
- apb_wdata  in  DATA_WIDTH  write data
- wstrb  in  4  write byte strobes
- apb_rdata  out  DATA_WIDTH  captured read data
- err_flag  out  1  transfer error
- apb_done  out  1  one-cycle completion pulse
- PADDR  out  ADDR_WIDTH  APB address
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PSTRB  out  4  APB strobes; 0 on reads
- PRDATA  in  NUM_SLAVES*DATA_WIDTH  flattened read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- PREADY  in  NUM_SLAVES  per-slave ready
- PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Clock and reset: single clock ACLK; reset is synchronous, active-low on ARESETn.
- Reset values: state IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, apb_rdata=0, err_flag=0, apb_done=0, timeout counter=0.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - On transfer=1 with write=1 or read=1, latch the request. Write wins if both are set.
  - Latch PADDR (apb_waddr or apb_raddr), PWRITE, PWDATA, PSTRB (wstrb on write, 0 on read) and slave index idx=addr[SEL_LSB +: SEL_W].
  - Clear err_flag and apb_rdata.
  - If idx < NUM_SLAVES, go to SETUP. Otherwise it is a decode error: go to DONE with err_flag=1, apb_rdata=0, and no PSEL asserted.
  - transfer with neither read nor write is ignored.
- SETUP: PSEL[idx]=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
- ACCESS:
  - PSEL[idx]=1, PENABLE=1; PADDR, PWRITE, PWDATA and PSTRB are held stable.
  - On the edge where PREADY[idx]=1: capture PRDATA slice idx into apb_rdata (reads only; writes leave 0) and err_flag=PSLVERR[idx]; go to DONE.
  - PSEL and PENABLE are both 0 in DONE.
- DONE: apb_done=1 for exactly one cycle, then go to IDLE.
- Hold rule: apb_rdata and err_flag hold their value until the next accepted transfer, because the front-end samples them several cycles after apb_done.
- Latency:
  - transfer sampled at edge 0, SETUP in cycle 1, ACCESS in cycle 2.
  - Zero-wait slave: apb_done in cycle 3. Each wait state adds one cycle.
  - Decode error: apb_done in cycle 1.
- transfer while not IDLE: ignored, no queuing.
- PREADY or PSLVERR of unselected slaves, and PREADY outside ACCESS: ignored.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values; no apb_done is issued.
- Back-to-back: a transfer arriving in the first IDLE cycle after DONE is accepted.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: an ACCESS-cycle counter starts at 0 on entry to ACCESS. If TIMEOUT_CYCLES ACCESS cycles elapse without PREADY[idx]:
  - abort, dropping PSEL/PENABLE next cycle;
  - go to DONE with err_flag=1, apb_rdata=0.
  - PREADY in the final allowed cycle wins over timeout.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Shared package apb_pkg: state encoding localparams (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, DONE=2'd3) and response codes (OKAY=2'b00, SLVERR=2'b10) shared with the front-end.
- One natural sub-module, apb_addr_decoder: combinational address to idx, one-hot select and decode-error flag.

Test Plan:
- Write 0x0000_2004, data 0xDEAD_BEEF, wstrb 0xF, slave 2 zero-wait -> PSEL=4'b0100; PENABLE only in cycle 2; PWDATA=0xDEADBEEF; apb_done in cycle 3; err_flag=0.
- Read 0x0000_1008, slave 1 PREADY low for 3 ACCESS cycles, PRDATA=0x1234_5678 -> PADDR/PSEL stable throughout; apb_done in cycle 6; apb_rdata=0x12345678 held until next transfer.
- Write to slave 0 with PSLVERR=1 at PREADY -> err_flag=1 and apb_done pulse; next transfer clears err_flag.
- Address 0x0000_5000 with NUM_SLAVES=4, SEL_W=3 (idx=5) -> no PSEL; apb_done in cycle 1; err_flag=1.
- APB_TIMEOUT_EN defined, PREADY stuck low -> abort after 16 ACCESS cycles with err_flag=1, apb_rdata=0. Macro undefined -> still in ACCESS after 100 cycles.
- ARESETn low during ACCESS -> next cycle PSEL=0, PENABLE=0, no apb_done; a subsequent transfer completes normally.
